// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nsa_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE, HOLD} nsa_state_t;

  localparam int NIBBLE_W = 4;

  // A single-nibble datapath still needs a 1-bit counter.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder; the V flag exists only with OVERFLOW_FLAG_EN.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  import nsa_pkg::*;

  // run is a level start request with no ready: it is sampled only in IDLE, and a held
  // level yields exactly one operation; done pulses one cycle with sum/cout already valid.
  logic             run;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef OVERFLOW_FLAG_EN
  logic             v;
`endif
  nsa_state_t       state;

  modport master (
    output run, sub, a, b,
`ifdef OVERFLOW_FLAG_EN
    input  v,
`endif
    input  sum, cout, busy, done, state
  );

  modport slave (
    input  run, sub, a, b,
`ifdef OVERFLOW_FLAG_EN
    output v,
`endif
    output sum, cout, busy, done, state
  );

endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit adder slice; c3 is the carry into bit 3, used for signed overflow.
module nibble_add4
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [3:0] low;
  logic [1:0] high;

  assign low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
  assign c3   = low[3];
  assign high = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
  assign s    = {high[0], low[2:0]};
  assign cout = high[1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, one nibble per clock, LSB first.
// Optional OVERFLOW_FLAG_EN adds a registered signed-overflow flag (bus.v).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nibble_serial_adder_if.slave    bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = cnt_width(NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  nsa_state_t       state_q, state_d;
  logic [CNT_W-1:0] nib_cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_co, nib_c3;

  assign nib_a = a_q[nib_cnt_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[nib_cnt_q*NIBBLE_W +: NIBBLE_W];

  nibble_add4 u_add4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_co),
    .c3   (nib_c3)
  );

  // Working value with the current nibble merged in, so the last step can publish it directly.
  always_comb begin
    work_d = work_q;
    work_d[nib_cnt_q*NIBBLE_W +: NIBBLE_W] = nib_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.run) state_d = CALC;
      CALC:    if (nib_cnt_q == LAST) state_d = DONE;
      DONE:    state_d = bus.run ? HOLD : IDLE;
      HOLD:    if (!bus.run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is folded in at latch time: invert B once and seed the carry with 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_cnt_q <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            a_q       <= bus.a;
            b_q       <= bus.b ^ {WIDTH{bus.sub}};
            carry_q   <= bus.sub;
            nib_cnt_q <= '0;
          end
        end
        CALC: begin
          work_q  <= work_d;
          carry_q <= nib_co;
          if (nib_cnt_q == LAST) begin
            sum_q  <= work_d;
            cout_q <= nib_co;
          end else begin
            nib_cnt_q <= nib_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic v_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= 1'b0;
    end else if (state_q == CALC && nib_cnt_q == LAST) begin
      v_q <= nib_c3 ^ nib_co;
    end
  end

  assign bus.v = v_q;
`endif

  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.busy  = (state_q == CALC);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed and random operations against an arithmetic model.
// Define OVERFLOW_FLAG_EN for both RTL and bench to check the V flag.
module tb_nibble_serial_adder;
  import nsa_pkg::*;

  parameter int WIDTH = 16;
  localparam int NIB = WIDTH / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entries are {cout, sum}.
  logic [WIDTH:0] exp_q[$];
`ifdef OVERFLOW_FLAG_EN
  logic exp_v_q[$];
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, b, input logic sub);
    logic [WIDTH:0] opb;
    opb = sub ? {1'b0, ~b} : {1'b0, b};
    return {1'b0, a} + opb + {{WIDTH{1'b0}}, sub};
  endfunction

`ifdef OVERFLOW_FLAG_EN
  function automatic logic model_v(input logic [WIDTH-1:0] a, b, input logic sub);
    longint sa, sb, res, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = sub ? (sa - sb) : (sa + sb);
    lim = longint'(1) << (WIDTH - 1);
    return (res >= lim) || (res < -lim);
  endfunction
`endif

  task automatic push_exp(input logic [WIDTH-1:0] a, b, input logic sub);
    exp_q.push_back(model(a, b, sub));
`ifdef OVERFLOW_FLAG_EN
    exp_v_q.push_back(model_v(a, b, sub));
`endif
  endtask

  task automatic check_result(input string tag);
    logic [WIDTH:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"}, bus.sum, e[WIDTH-1:0]);
    check({tag, "_cout"}, bus.cout, e[WIDTH]);
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_v"}, bus.v, (exp_v_q.size() > 0) ? exp_v_q.pop_front() : 1'b0);
`endif
  endtask

  // ---------------- drivers ----------------
  // One Run pulse; operands are scrambled right after latching and must not matter.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic sub);
    logic [WIDTH-1:0] prev_sum;
    int busy_cyc;
    int cyc;
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.sub = sub;
    bus.run = 1'b1;
    push_exp(a, b, sub);
    prev_sum = bus.sum;
    @(negedge clk);
    bus.run = 1'b0;
    bus.a   = WIDTH'($urandom);
    bus.b   = WIDTH'($urandom);
    bus.sub = 1'($urandom_range(0, 1));
    busy_cyc = 0;
    cyc = 1;
    while (!bus.done && cyc <= 4 * NIB + 8) begin
      if (bus.busy) busy_cyc++;
      check("sum_hold", bus.sum, prev_sum);
      @(negedge clk);
      cyc++;
    end
    check("done_seen", bus.done, 1'b1);
    check("done_cycle", cyc, NIB + 1);
    check("busy_cycles", busy_cyc, NIB);
    check_result("op");
    @(negedge clk);
    check("done_pulse", bus.done, 1'b0);
    check("back_idle", bus.state, IDLE);
  endtask

  task automatic held_run_test();
    logic [WIDTH-1:0] a0, b0;
    int dones;
    a0 = WIDTH'($urandom);
    b0 = WIDTH'($urandom);
    @(negedge clk);
    bus.a   = a0;
    bus.b   = b0;
    bus.sub = 1'b1;
    bus.run = 1'b1;
    push_exp(a0, b0, 1'b1);
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check_result("held");
      end
      if (i == 2) begin
        bus.a   = ~a0;
        bus.b   = a0 ^ b0;
        bus.sub = 1'b0;
      end
    end
    check("held_one_done", dones, 1);
    check("held_state", bus.state, HOLD);
    bus.run = 1'b0;
    @(negedge clk);
    check("held_release", bus.state, IDLE);
  endtask

  task automatic reset_mid_op_test();
    int dones;
    @(negedge clk);
    bus.a   = WIDTH'($urandom);
    bus.b   = WIDTH'($urandom);
    bus.sub = 1'b0;
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_sum", bus.sum, '0);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state", bus.state, IDLE);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) reset_n = 1'b1;
      if (bus.done) dones++;
    end
    check("rst_no_done", dones, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0;
    bus.sub = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    #1;
    check("reset_sum", bus.sum, '0);
    check("reset_cout", bus.cout, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_state", bus.state, IDLE);
`ifdef OVERFLOW_FLAG_EN
    check("reset_v", bus.v, 1'b0);
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_op(WIDTH'(16'h1234), WIDTH'(16'h0FFF), 1'b0);
    run_op(WIDTH'(16'hFFFF), WIDTH'(16'h0001), 1'b0);
    run_op(WIDTH'(16'h0005), WIDTH'(16'h0007), 1'b1);
    run_op(WIDTH'(16'h0007), WIDTH'(16'h0005), 1'b1);
    run_op(WIDTH'(16'h7FFF), WIDTH'(16'h0001), 1'b0);
    run_op(WIDTH'(16'h8000), WIDTH'(16'h0001), 1'b1);
    run_op(WIDTH'(16'h0001), WIDTH'(16'h0001), 1'b0);
    run_op('0, '0, 1'b1);
    run_op('1, '1, 1'b0);

    held_run_test();
    run_op(WIDTH'(16'h0F0F), WIDTH'(16'h00F1), 1'b0);

    reset_mid_op_test();
    run_op(WIDTH'(16'hABCD), WIDTH'(16'h1357), 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
